// File: rtl/cpu_pkg.sv
// Shared constants and FSM encoding for the instruction-memory boot loader.
// The stream starts with a little-endian word count of BOOT_LEN_BYTES bytes.
package cpu_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int BOOT_LEN_BYTES = 2;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } boot_state_e;

endpackage

// File: rtl/boot_word_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word and emits a
// one-cycle word_valid pulse the cycle after the fourth byte is accepted.
module boot_word_assembler
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              last_byte,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_valid_q;
    wire  [WORD_W-BYTE_W-1:0] lanes;

    assign last_byte = byte_valid && (idx_q == 2'(BYTES_PER_WORD - 1));

    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (byte_valid) begin
            idx_d = idx_q + 2'd1;
        end
    end

    // Lower three lanes are held until the top byte arrives; the top byte is
    // folded straight into the output word so there is no extra bubble.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD - 1; gi = gi + 1) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [BYTE_W-1:0] lane_q, lane_d;

            always_comb begin
                lane_d = lane_q;
                if (byte_valid && (idx_q == LANE)) begin
                    lane_d = byte_data;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lane_q <= '0;
                end else begin
                    lane_q <= lane_d;
                end
            end

            assign lanes[gi*BYTE_W +: BYTE_W] = lane_q;
        end
    endgenerate

    always_comb begin
        word_d = word_q;
        if (last_byte) begin
            word_d = {byte_data, lanes};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            word_q       <= word_d;
            word_valid_q <= last_byte;
        end
    end

    assign word_valid = word_valid_q;
    assign word       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: writes the image into instruction memory from word 0
// and releases the core once loaded. Define IMEM_BOOT_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_boot_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  start,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [WORD_W-1:0]     imem_wdata,
    output logic                  cpu_run,
    output logic                  done,
    output logic                  error
);

    localparam int               LEN_W   = BOOT_LEN_BYTES * BYTE_W;
    localparam int               LEN_W1  = LEN_W + 1;
    localparam logic [LEN_W:0]   MAX_LEN = LEN_W1'(MAX_WORDS);

    boot_state_e           state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  run_q, run_d;

    logic                  accept;
    logic                  restart;
    logic                  asm_valid;
    logic                  asm_clear;
    logic                  asm_last;
    logic [LEN_W-1:0]      len_full;
    logic                  len_bad;

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [BYTE_W-1:0]     csum_q, csum_d;
`endif

    assign accept    = in_valid && in_ready;
    assign restart   = start && ((state_q == DONE) || (state_q == ERR));
    assign asm_valid = accept && (state_q == DATA);
    // The high length byte is still on in_data when the limit is checked.
    assign len_full  = {in_data, len_q[BYTE_W-1:0]};
    assign len_bad   = (len_full == '0) || ({1'b0, len_full} > MAX_LEN);

    boot_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_data  (in_data),
        .last_byte  (asm_last),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= LEN_LO;
            len_q      <= '0;
            word_cnt_q <= '0;
            waddr_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            waddr_q    <= waddr_d;
            done_q     <= done_d;
            error_q    <= error_d;
            run_q      <= run_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        waddr_d    = waddr_q;
        asm_clear  = 1'b0;
        case (state_q)
            LEN_LO: begin
                if (accept) begin
                    len_d[BYTE_W-1:0] = in_data;
                    state_d           = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_bad) begin
                        state_d = ERR;
                    end else begin
                        state_d    = DATA;
                        word_cnt_d = '0;
                        asm_clear  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (asm_last) begin
                    waddr_d    = word_cnt_q[ADDR_WIDTH-1:0];
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_d == len_q) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = WAIT;
`endif
                    end
                end
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? WAIT : ERR;
                end
            end
`endif
            WAIT: begin
                state_d = DONE;
            end
            DONE, ERR: begin
                if (restart) begin
                    state_d    = LEN_LO;
                    len_d      = '0;
                    word_cnt_d = '0;
                    asm_clear  = 1'b1;
                end
            end
            default: begin
                state_d = LEN_LO;
            end
        endcase
    end

    // Status flags are registered from the next state so they rise with DONE/ERR.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            LEN_LO, LEN_HI, DATA: in_ready = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            CHK:                  in_ready = 1'b1;
`endif
            default:              in_ready = 1'b0;
        endcase
        done_d  = (state_d == DONE);
        run_d   = (state_d == DONE);
        error_d = (state_d == ERR);
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    always_comb begin
        csum_d = csum_q;
        if (restart) begin
            csum_d = '0;
        end else if (accept && (state_q != CHK)) begin
            csum_d = csum_q ^ in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign imem_waddr = waddr_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_run    = run_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream loader for the single-cycle RISC-V core: receives a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit instruction words and writes them into instruction memory starting at word address 0.
- Holds the core in reset until the image is fully loaded, then releases it so execution starts from PC 0.
- Stream format: 2-byte word count (LSB first), then count×4 data bytes (LSB first per word), then an optional checksum byte.

Parameters:
- ADDR_WIDTH, 8, width of the instruction-memory word address.
- MAX_WORDS, 256, largest accepted word count; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, asynchronous, active-low.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte.
- start  input  1  single-cycle pulse; restarts loading, honoured only in DONE/ERR.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_waddr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  instruction word for the write.
- cpu_run  output  1  1 = core released from reset; drives the core's reset via inversion at integration.
- done  output  1  image loaded successfully.
- error  output  1  bad length or checksum mismatch.

Behaviour:
- Reset values:
  - state = LEN_LO.
  - in_ready = 1.
  - imem_we = 0, imem_waddr = 0, imem_wdata = 0.
  - cpu_run = 0, done = 0, error = 0.
  - Byte counter, word counter and length register are cleared.
- Byte transfer: a byte is accepted on a rising edge with in_valid & in_ready. in_ready is a combinational decode of state: 1 in LEN_LO, LEN_HI, DATA and CHK; 0 in WAIT, DONE and ERR. in_data is ignored when no transfer occurs.
- State machine:
  - LEN_LO: accept byte → len[7:0]; go to LEN_HI.
  - LEN_HI: accept byte → len[15:8]. If the 16-bit len is 0 or > MAX_WORDS, go to ERR; otherwise go to DATA with word count = 0 and byte index = 0.
  - DATA: accepted byte k of the word goes to lanes [8k+7:8k], k = 0..3.
    - On the 4th byte: the next cycle has imem_we = 1 for exactly one cycle, imem_wdata = the assembled word and imem_waddr = word count (first word at address 0). Latency from last byte accepted to strobe is 1 cycle.
    - The word count increments. Back-to-back bytes are sustained with no bubbles.
    - After the final word's 4th byte, go to CHK if checksum is enabled, else WAIT.
  - WAIT: one cycle, which coincides with the final imem_we pulse; then go to DONE.
  - DONE: done = 1 and cpu_run = 1 (registered, asserted the cycle after the final strobe). Stays until start or reset.
  - ERR: error = 1 and cpu_run = 0. No writes. Stays until start or reset.
- start in DONE/ERR: the next cycle clears done, error and cpu_run and counters, and goes to LEN_LO. start in any other state is ignored.
- Reset mid-load: everything returns to reset values, the partial word is discarded and no write strobe is issued. Memory contents already written are left as they are.
- Boundaries:
  - len = MAX_WORDS is legal and writes addresses 0..MAX_WORDS-1; no address wrap.
  - len = MAX_WORDS+1 → ERR.
  - Multi-byte len values are valid up to 65535 before the limit check.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - A running XOR of every accepted byte (length and data) is kept.
  - After the last data byte, the loader enters CHK and accepts one byte. If it equals the running XOR, go to WAIT → DONE; otherwise go to ERR.
  - When entering ERR from CHK, the last word's imem_we pulse still occurs, but cpu_run stays 0.
- Undefined: no CHK state and no XOR register; the stream ends after the data bytes.

Decomposition:
- Shared package cpu_pkg:
  - state enum localparams: LEN_LO, LEN_HI, DATA, CHK, WAIT, DONE, ERR.
  - word width 32 and byte width 8 constants.
  - BOOT_LEN_BYTES = 2.
- One natural sub-module, boot_word_assembler: byte-lane shift/assemble register with a 2-bit byte index, emitting word_valid and word.
- The FSM, counters and checksum stay in imem_boot_loader.

Test Plan:
- Length 1, bytes 01 00 93 00 50 00 → one imem_we with addr 0, data 0x00500093; done = 1 and cpu_run = 1 one cycle after the strobe; in_ready = 0 in DONE.
- Length 3 streamed back-to-back, then the same stream with in_valid toggled randomly → three strobes at addr 0, 1, 2 with the correct words; identical memory image in both runs; no strobe before the 4th byte of each word.
- Length bytes 00 00, and separately 01 01 (257, with MAX_WORDS = 256) → error = 1, no imem_we, cpu_run = 0; start pulse → back to LEN_LO and a valid reload then succeeds.
- Reset asserted after 2 data bytes of word 1 → outputs at reset values immediately (asynchronously); reload of length 1 writes addr 0 correctly; the old partial word is never written.
- Length 256 → 256 strobes with addresses 0x00..0xFF, no wrap, done = 1; start pulse in DATA mid-load is ignored.
- With IMEM_BOOT_CHECKSUM_EN, stream 01 00 93 00 50 00 followed by checksum C2 → done. Same stream followed by C3 → error = 1, cpu_run = 0, and the addr-0 write still occurs.
